// File: rtl/pdm_beam_pkg.sv
// rtl/pdm_beam_pkg.sv - shared types and default sizing for the beam scan controller
package pdm_beam_pkg;

  localparam int DEF_MAX_LAG = 7;
  localparam int DEF_EW      = 16;
  localparam int DEF_LW      = $clog2(DEF_MAX_LAG + 1) + 1;
  localparam int N_LAGS      = 2 * DEF_MAX_LAG + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INTEG,
    SETTLE,
    CAPTURE,
    DONE
  } scan_state_t;

  typedef logic signed [DEF_LW-1:0] lag_t;
  typedef logic signed [DEF_EW-1:0] energy_t;

endpackage

// File: rtl/beam_scan_ctrl_if.sv
// rtl/beam_scan_ctrl_if.sv - host, PDM and accumulator signals of the beam scan controller
interface beam_scan_ctrl_if #(
  parameter int WINDOW_SIZE = 16,
  parameter int MAX_LAG     = 7,
  parameter int EW          = 16
);
  localparam int PW = $clog2(WINDOW_SIZE);
  localparam int LW = $clog2(MAX_LAG + 1) + 1;

  logic                 start;
  logic                 abort;
  logic                 pdm_valid;
  logic signed [EW-1:0] energy_in;
  logic [PW-1:0]        pos_1;
  logic [PW-1:0]        pos_2;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 busy;
  logic                 done;
  logic signed [LW-1:0] best_lag;
  logic signed [EW-1:0] best_energy;

  modport master (
    input  start, abort, pdm_valid, energy_in,
    output pos_1, pos_2, acc_clr, acc_en, busy, done, best_lag, best_energy
  );

  modport slave (
    output start, abort, pdm_valid, energy_in,
    input  pos_1, pos_2, acc_clr, acc_en, busy, done, best_lag, best_energy
  );

endinterface

// File: rtl/beam_scan_ctrl_peak_hold.sv
// rtl/beam_scan_ctrl_peak_hold.sv - keeps the highest signed energy seen in a scan and its lag
module peak_hold #(
  parameter int LW = 4,
  parameter int EW = 16
) (
  input  logic                 s_clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic                 first,
  input  logic signed [LW-1:0] lag_in,
  input  logic signed [EW-1:0] energy_in,
  output logic signed [LW-1:0] best_lag,
  output logic signed [EW-1:0] best_energy
);

  // Strict greater-than: on a tie the earlier (more negative) lag is kept.
  always_ff @(posedge s_clk) begin
    if (n_rst) begin
      best_lag    <= '0;
      best_energy <= '0;
    end else if (load && (first || (energy_in > best_energy))) begin
      best_lag    <= lag_in;
      best_energy <= energy_in;
    end
  end

endmodule

// File: rtl/beam_scan_ctrl.sv
// rtl/beam_scan_ctrl.sv - steps the delay-sum taps through every lag and reports the peak-energy lag
module beam_scan_ctrl
  import pdm_beam_pkg::*;
#(
  parameter int WINDOW_SIZE = 16,
  parameter int MAX_LAG     = 7,
  parameter int INTEG_LEN   = 1024,
  parameter int EW          = 16
) (
  input  logic          s_clk,
  input  logic          n_rst,
  beam_scan_ctrl_if.master bus
);

  localparam int PW = $clog2(WINDOW_SIZE);
  localparam int LW = $clog2(MAX_LAG + 1) + 1;
  localparam logic signed [LW-1:0] LAG_FIRST = LW'(-MAX_LAG);
  localparam logic signed [LW-1:0] LAG_LAST  = LW'(MAX_LAG);
  localparam logic [16:0]          CNT_LAST  = 17'(INTEG_LEN);

  generate
    if (2 * MAX_LAG + 1 > WINDOW_SIZE) begin : g_bad_lag
      $error("beam_scan_ctrl: 2*MAX_LAG+1 exceeds WINDOW_SIZE");
    end
    if (INTEG_LEN < 1 || INTEG_LEN > 65535) begin : g_bad_len
      $error("beam_scan_ctrl: INTEG_LEN out of range 1..65535");
    end
  endgenerate

  scan_state_t          state, state_n;
  logic signed [LW-1:0] lag, lag_n;
  logic [15:0]          cnt;
  logic                 cnt_hit;
  logic                 busy_c;
  logic [PW-1:0]        tap_n;

  assign cnt_hit = bus.pdm_valid && (({1'b0, cnt} + 17'd1) == CNT_LAST);
  assign tap_n   = PW'(MAX_LAG + int'(lag_n));

  always_ff @(posedge s_clk) begin
    if (n_rst) begin
      state     <= IDLE;
      lag       <= '0;
      cnt       <= '0;
      bus.pos_1 <= PW'(MAX_LAG);
      bus.pos_2 <= PW'(MAX_LAG);
    end else begin
      state <= state_n;
      lag   <= lag_n;
      if (state == CLEAR)
        cnt <= '0;
      else if (state == INTEG && bus.pdm_valid)
        cnt <= cnt + 16'd1;
      // Taps are loaded on entry so they already match the new lag during CLEAR.
      if (state_n == CLEAR) begin
        bus.pos_1 <= PW'(MAX_LAG);
        bus.pos_2 <= tap_n;
      end
    end
  end

  always_comb begin
    state_n     = state;
    lag_n       = lag;
    busy_c      = 1'b0;
    bus.acc_clr = 1'b0;
    bus.acc_en  = 1'b0;
    bus.done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n = CLEAR;
          lag_n   = LAG_FIRST;
        end
      end
      CLEAR: begin
        busy_c      = 1'b1;
        bus.acc_clr = 1'b1;
        state_n     = INTEG;
      end
      INTEG: begin
        busy_c     = 1'b1;
        bus.acc_en = 1'b1;
        if (cnt_hit)
          state_n = SETTLE;
      end
      SETTLE: begin
        busy_c  = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: begin
        busy_c = 1'b1;
        if (lag == LAG_LAST) begin
          state_n = DONE;
        end else begin
          lag_n   = lag + LW'(1);
          state_n = CLEAR;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          state_n = CLEAR;
          lag_n   = LAG_FIRST;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (busy_c && bus.abort) begin
      state_n = IDLE;
      lag_n   = lag;
    end
  end

  assign bus.busy = busy_c;

  peak_hold #(
    .LW(LW),
    .EW(EW)
  ) u_peak_hold (
    .s_clk      (s_clk),
    .n_rst      (n_rst),
    .load       ((state == CAPTURE) && !bus.abort),
    .first      (lag == LAG_FIRST),
    .lag_in     (lag),
    .energy_in  (bus.energy_in),
    .best_lag   (bus.best_lag),
    .best_energy(bus.best_energy)
  );

endmodule

// File: doc/beam_scan_ctrl.md
Name: beam_scan_ctrl

Overview:
Scan controller for the PDM delay-and-sum beamformer. It steps a run-time tap-select delay-sum accumulator through every inter-mic lag from -MAX_LAG to +MAX_LAG. For each lag it clears the energy counter, integrates over INTEG_LEN PDM samples and captures the result. It reports the lag with maximum energy, giving a direction-of-arrival estimate to the host/LED logic.

Parameters:
WINDOW_SIZE, 16, length of left/right PDM rolling buffers; tap indices must stay in 0..WINDOW_SIZE-1
MAX_LAG, 7, max |lag| in samples; constraint 2*MAX_LAG+1 <= WINDOW_SIZE (elaboration assertion)
INTEG_LEN, 1024, PDM sample strobes integrated per lag; range 1..65535
EW, 16, energy width (two's complement)

Ports:
s_clk  in  1  system clock
n_rst  in  1  reset; synchronous, active-high (asserted = 1)
start  in  1  1-cycle pulse; begins a scan when idle; ignored when busy
abort  in  1  1-cycle pulse; terminates the scan
pdm_valid  in  1  new PDM bit pair shifted into the rolling buffers this cycle
energy_in  in  EW  accumulator value, signed; updated 1 cycle after an enabled pdm_valid
pos_1  out  $clog2(WINDOW_SIZE)  left tap index
pos_2  out  $clog2(WINDOW_SIZE)  right tap index
acc_clr  out  1  clears the accumulator to 0 (synchronous, next edge)
acc_en  out  1  accumulator may count this cycle (acc_en & pdm_valid)
busy  out  1  scan in progress
done  out  1  1-cycle pulse when a scan completes
best_lag  out  LW  signed winning lag, LW = $clog2(MAX_LAG+1)+1
best_energy  out  EW  signed energy at best_lag

Behaviour:
- Reset (n_rst=1 at an edge) → state IDLE. All outputs 0 except pos_1 = pos_2 = MAX_LAG. Lag counter 0. Sample counter 0. Dominates start and abort.
- Tap mapping for current lag L: pos_1 = MAX_LAG, pos_2 = MAX_LAG + L. pos_1/pos_2 are registered and change only in CLEAR.
- States:
  - IDLE: busy=0. start → CLEAR with L = -MAX_LAG, best_energy/best_lag unchanged until the first capture.
  - CLEAR: 1 cycle. acc_clr=1, acc_en=0. Taps = L. Sample counter ← 0. → INTEG.
  - INTEG: acc_en=1. Counts pdm_valid strobes. On the strobe that makes count == INTEG_LEN → SETTLE. acc_en drops the cycle after that strobe, so exactly INTEG_LEN samples are enabled.
  - SETTLE: 1 cycle, acc_en=0, covering accumulator latency. → CAPTURE.
  - CAPTURE: 1 cycle. Sample energy_in (signed compare).
    - First lag of the scan: load best unconditionally.
    - Later lags: replace only if energy_in > best_energy (strict); ties keep the more negative lag.
    - If L == +MAX_LAG → DONE; else L ← L+1 and → CLEAR.
  - DONE: done=1 for 1 cycle, busy=0 → IDLE. best_* hold until the next scan's first capture.
- busy=1 in CLEAR, INTEG, SETTLE, CAPTURE; busy=0 in IDLE and DONE. A start in the DONE cycle is accepted and goes to CLEAR.
- abort in any busy state → IDLE next edge. No done pulse. acc_en=0. best_* hold whatever the last capture wrote. abort in IDLE/DONE: no effect. abort and start in the same IDLE cycle: abort wins (stay IDLE).
- pdm_valid during CLEAR, SETTLE or CAPTURE is not counted (the accumulator is disabled).
- Scan length in cycles: (2*MAX_LAG+1) × (3 + cycles to collect INTEG_LEN strobes) + 1.
- Sample counter is 16 bits with no wrap; INTEG_LEN=1 is legal (INTEG lasts until the first strobe).

Decomposition:
- Package pdm_beam_pkg:
  - state enum scan_state_t {IDLE, CLEAR, INTEG, SETTLE, CAPTURE, DONE}
  - localparam N_LAGS = 2*MAX_LAG+1
  - lag_t (signed LW)
  - energy_t (signed EW)
- One sub-module, peak_hold: load/compare/update of best_energy/best_lag, with a first-flag input and strict-greater rule. The FSM, counters and tap mapping stay in beam_scan_ctrl.

Test Plan:
- Reset mid-INTEG (n_rst=1 for 1 cycle) → next cycle IDLE, busy=0, acc_en=0, pos_1=pos_2=7, best_lag=0, best_energy=0.
- MAX_LAG=7, INTEG_LEN=4, pdm_valid every cycle, bench model returns energy = 100 - 10*|L-3| → 15 CLEAR pulses, pos_2 stepping 0..14, done after 15×7+1 cycles, best_lag=+3, best_energy=100.
- pdm_valid every 3rd cycle, INTEG_LEN=4 → acc_en high for exactly 4 enabled strobes per lag; strobes in CLEAR/SETTLE are ignored (counter check).
- Negative energies: energy = -50 for all lags except L=-7 giving -60 → best_lag=-6, best_energy=-50 (signed compare; tie keeps first).
- abort at lag 0 during INTEG → IDLE, no done, best_* equal to the max over lags -7..-1; a subsequent start rescans from -7.
- start held 1 throughout a scan → only one scan per accepted start; restart in the DONE cycle → CLEAR on the next edge with pos_2=0.
